// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Multi-cycle mult/div with fixed latency; single-cycle mthi/mtlo.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_we;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_ovf;
    logic        accept;

    assign accept = start && !busy;

    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'b0, A} * {32'b0, B};
        // Divisor forced non-zero so the arithmetic never sees x; zero-divide results are dropped.
        divisor = (B == 32'd0) ? 32'd1 : B;
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        quot_u  = A / divisor;
        rem_u   = A % divisor;
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(A) / $signed(divisor);
            rem_s  = $signed(A) % $signed(divisor);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                cnt  <= '0;
                if (pend_we) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (accept) begin
            case (MDUOp)
                OP_MULT: begin
                    {pend_hi, pend_lo} <= prod_s;
                    pend_we <= 1'b1;
                    cnt     <= CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                end
                OP_MULTU: begin
                    {pend_hi, pend_lo} <= prod_u;
                    pend_we <= 1'b1;
                    cnt     <= CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                end
                OP_DIV: begin
                    pend_hi <= rem_s;
                    pend_lo <= quot_s;
                    pend_we <= (B != 32'd0);
                    cnt     <= CW'(DIV_CYCLES);
                    busy    <= 1'b1;
                end
                OP_DIVU: begin
                    pend_hi <= rem_u;
                    pend_lo <= quot_u;
                    pend_we <= (B != 32'd0);
                    cnt     <= CW'(DIV_CYCLES);
                    busy    <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against
// a 64-bit arithmetic reference model of HI/LO and busy duration.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial forever #5 clk = ~clk;

    function automatic int exp_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural HI/LO state.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd1: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                p = ua / ub; exp_lo = p[31:0];
                p = ua % ub; exp_hi = p[31:0];
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, scramble operands afterwards, and measure busy length.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] hi_mid, output logic [31:0] lo_mid);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
        hi_mid = HI; lo_mid = LO;
        cyc = 0;
        while (busy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, HI, LO} !== 65'd0) begin
            bad++; $display("FAIL reset: busy=%b HI=%h LO=%h, required all 0", busy, HI, LO);
        end
        @(negedge clk); reset = 1'b0;
        exp_hi = 0; exp_lo = 0;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] as  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] bs  [4] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0};
        int cyc; logic [31:0] hm, lm;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                run_op(3'd5, 32'h11, 0, cyc, hm, lm); model(3'd5, 32'h11, 0);
                run_op(3'd6, 32'h22, 0, cyc, hm, lm); model(3'd6, 32'h22, 0);
            end
            run_op(ops[i], as[i], bs[i], cyc, hm, lm);
            total++;
            if (hm !== exp_hi || lm !== exp_lo) begin
                bad++; $display("FAIL directed%0d_preop: HI=%h LO=%h, required %h %h", i, hm, lm,
                                exp_hi, exp_lo);
            end
            model(ops[i], as[i], bs[i]);
            total++;
            if (cyc != exp_cycles(ops[i]) || HI !== exp_hi || LO !== exp_lo) begin
                bad++; $display("FAIL directed%0d: cyc=%0d HI=%h LO=%h, required %0d %h %h", i, cyc,
                                HI, LO, exp_cycles(ops[i]), exp_hi, exp_lo);
            end
        end
        // Spot-check literal values from the datasheet-level examples.
        total++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            bad++; $display("FAIL divu_zero: HI=%h LO=%h, required 00000011 00000022", HI, LO);
        end
    endtask

    task automatic test_div_overflow;
        int cyc; logic [31:0] hm, lm;
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, hm, lm);
        model(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        total++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000 || cyc != 10) begin
            bad++; $display("FAIL div_ovf: cyc=%0d HI=%h LO=%h, required 10 00000000 80000000", cyc,
                            HI, LO);
        end
    endtask

    task automatic test_ignore_busy;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd1; A = 32'd1000; B = 32'hFFFF_FFF0;
        @(posedge clk); #1; start = 1'b0;
        model(3'd1, 32'd1000, 32'hFFFF_FFF0);
        @(posedge clk); #1; cyc++;
        // Busy cycle 2: a div and an mthi must both be dropped.
        @(negedge clk); start = 1'b1; MDUOp = 3'd3; A = 32'd99; B = 32'd4;
        @(posedge clk); #1; cyc++;
        @(negedge clk); MDUOp = 3'd5; A = 32'hDEAD_BEEF;
        @(posedge clk); #1; cyc++;
        @(negedge clk); start = 1'b0;
        while (busy && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (cyc != 5 || HI !== exp_hi || LO !== exp_lo) begin
            bad++; $display("FAIL ignore_busy: cyc=%0d HI=%h LO=%h, required 5 %h %h", cyc, HI, LO,
                            exp_hi, exp_lo);
        end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            bad++; $display("FAIL ignore_busy_late: busy=%b HI=%h LO=%h", busy, HI, LO);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; logic [31:0] hm, lm;
        run_op(3'd5, 32'hAAAA, 0, cyc, hm, lm);
        @(negedge clk); start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        total++;
        if ({busy, HI, LO} !== 65'd0) begin
            bad++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h, required all 0", busy, HI, LO);
        end
        @(negedge clk); reset = 1'b0;
        exp_hi = 0; exp_lo = 0;
        repeat (15) @(posedge clk);
        #1;
        total++;
        if ({busy, HI, LO} !== 65'd0) begin
            bad++; $display("FAIL reset_late_write: busy=%b HI=%h LO=%h", busy, HI, LO);
        end
    endtask

    task automatic test_mthi_mtlo;
        int seen = 0;
        @(negedge clk); start = 1'b1; MDUOp = 3'd5; A = 32'h1234;
        @(posedge clk); #1; seen += int'(busy);
        @(negedge clk); MDUOp = 3'd6; A = 32'h5678;
        @(posedge clk); #1; seen += int'(busy);
        total++;
        if (HI !== 32'h1234) begin
            bad++; $display("FAIL mthi: HI=%h, required 00001234", HI);
        end
        @(negedge clk); start = 1'b0; MDUOp = 3'd0;
        @(posedge clk); #1; seen += int'(busy);
        model(3'd5, 32'h1234, 0); model(3'd6, 32'h5678, 0);
        total++;
        if (HI !== 32'h1234 || LO !== 32'h5678 || seen != 0) begin
            bad++; $display("FAIL mtlo: HI=%h LO=%h busy_seen=%0d, required 1234 5678 0", HI, LO,
                            seen);
        end
    endtask

    task automatic test_random;
        int cyc; logic [31:0] hm, lm, a, b; logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
            run_op(op, a, b, cyc, hm, lm);
            model(op, a, b);
            total++;
            if (cyc != exp_cycles(op) || HI !== exp_hi || LO !== exp_lo) begin
                bad++; $display("FAIL random%0d op=%0d a=%h b=%h: cyc=%0d HI=%h LO=%h, required %0d %h %h",
                                i, op, a, b, cyc, HI, LO, exp_cycles(op), exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_overflow();
        test_ignore_busy();
        test_reset_mid();
        test_mthi_mtlo();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
